// File: rtl/cbus_sram_responder.sv
// cbus memory-side responder: fixed-latency, one beat per cycle, backed by a
// 64-bit word array. Handles FIXED/INCR/WRAP bursts and per-byte write strobes.

package cbus_pkg;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_e;

  // len is beats minus one (MLEN1), so 4 bits cover 1..16 beats
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic        is_write;
    logic [3:0]  len;
    cbus_burst_e burst;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] TOP_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_COOL} state_e;

  state_e      state;
  logic [63:0] addr_q;
  logic        wr_q;
  logic [3:0]  len_q;
  cbus_burst_e burst_q;
  logic [3:0]  lat_cnt;
  logic [3:0]  beat;
  logic [63:0] mem [DEPTH_WORDS];

  // WRAP only wraps for 2/4/8/16 beats; the (beats*8)-1 mask is then {len,3'b111}
  function automatic logic [63:0] beat_addr(input logic [3:0] i);
    logic [63:0] inc;
    logic [63:0] mask;
    inc  = addr_q + {57'd0, i, 3'd0};
    mask = {57'd0, len_q, 3'b111};
    if (burst_q == BURST_FIXED)
      return addr_q;
    else if (burst_q == BURST_WRAP && len_q != 4'd0 && (len_q & (len_q + 4'd1)) == 4'd0)
      return (addr_q & ~mask) | (inc & mask);
    else
      return inc;
  endfunction

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && (a < TOP_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
    return AW'((a - BASE_ADDR) >> 3);
  endfunction

  // read side looks one beat ahead so data lands in the same cycle as ready
  logic [3:0]    rd_beat;
  logic [63:0]   rd_addr, wr_addr, rd_data;
  logic          rd_ok, wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;

  assign rd_beat = (state == S_BEAT) ? beat + 4'd1 : 4'd0;
  assign rd_addr = beat_addr(rd_beat);
  assign wr_addr = beat_addr(beat);
  assign rd_ok   = in_range(rd_addr);
  assign wr_ok   = in_range(wr_addr);
  assign rd_idx  = word_idx(rd_addr);
  assign wr_idx  = word_idx(wr_addr);
  assign rd_data = rd_ok ? mem[rd_idx] : 64'd0;

  logic unused_size;
  assign unused_size = ^req.size;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      resp    <= '0;
      err     <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
      lat_cnt <= '0;
      beat    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req.valid) begin
          addr_q  <= req.addr;
          wr_q    <= req.is_write;
          len_q   <= req.len;
          burst_q <= req.burst;
          lat_cnt <= 4'(LATENCY - 1);
          beat    <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state      <= S_BEAT;
            resp.ready <= 1'b1;
            resp.last  <= (len_q == 4'd0);
            resp.data  <= wr_q ? 64'd0 : rd_data;
            err        <= !rd_ok;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_BEAT: begin
          if (beat == len_q) begin
            state <= S_COOL;
            resp  <= '0;
            err   <= 1'b0;
          end else begin
            beat      <= beat + 4'd1;
            resp.last <= (rd_beat == len_q);
            resp.data <= wr_q ? 64'd0 : rd_data;
            err       <= !rd_ok;
          end
        end
        S_COOL: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; state leaves BEAT asynchronously on reset, so an
  // interrupted beat is never committed.
  always_ff @(posedge clk) begin
    if (state == S_BEAT && wr_q && wr_ok)
      for (int k = 0; k < 8; k++)
        if (req.strobe[k]) mem[wr_idx][8*k +: 8] <= req.data[8*k +: 8];
  end
endmodule
